run_pattern_detector: RTL

Parametrised, clocked run-length detector for a serial switch/bit stream. It counts consecutive ones and zeros on qualified samples and pulses when a run reaches its programmed length. It drives level or sticky LED indicators and keeps saturating event counters. It sits between the switch/sample front end and the LED and status outputs, and replaces the fixed 8-input combinational pattern check.

---
 rtl/run_detect_pkg.sv | 23 ++
 rtl/run_counter.sv | 73 +++++++
 rtl/run_pattern_detector.sv | 78 +++++++
 3 files changed

// File: rtl/run_detect_pkg.sv
// Shared constants, width helper and per-polarity run state for run_pattern_detector.
// Build option: RUN_DETECT_STICKY_EN selects sticky LED behaviour in run_counter.
package run_detect_pkg;

    localparam int DEF_ONES_RUN  = 3;
    localparam int DEF_ZEROS_RUN = 2;
    localparam int DEF_MAX_RUN   = 15;
    localparam int DEF_EVW       = 8;

    // Internal run-count width; any legal MAX_RUN must fit in it.
    localparam int RUN_CNT_W = 16;

    typedef struct packed {
        logic [RUN_CNT_W-1:0] count;
        logic                 hit;
        logic                 led;
    } run_state_t;

    function automatic int run_cw(input int max_run);
        return $clog2(max_run + 1);
    endfunction

endpackage

// File: rtl/run_counter.sv
// One polarity of the run detector: saturating run count, hit pulse, LED and event counter.
// RUN_DETECT_STICKY_EN defined: LED latches on hit until clear/rst; otherwise LED = (count >= RUN_LEN).
module run_counter
    import run_detect_pkg::*;
#(
    parameter bit  POLARITY = 1'b1,
    parameter int  RUN_LEN  = DEF_ONES_RUN,
    parameter int  MAX_RUN  = DEF_MAX_RUN,
    parameter int  EVW      = DEF_EVW,
    localparam int CW       = run_cw(MAX_RUN)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clear,
    input  logic           accept,
    input  logic           bit_in,
    output logic [CW-1:0]  run_len,
    output logic           hit,
    output logic           led,
    output logic [EVW-1:0] events
);

    localparam logic [RUN_CNT_W-1:0] MAX_C  = RUN_CNT_W'(MAX_RUN);
    localparam logic [RUN_CNT_W-1:0] LEN_C  = RUN_CNT_W'(RUN_LEN);
    localparam logic [RUN_CNT_W-1:0] LEN_M1 = RUN_CNT_W'(RUN_LEN - 1);

    run_state_t     state_q, state_d;
    logic [EVW-1:0] events_q, events_d;
    logic           match;

    always_comb begin
        state_d     = state_q;
        state_d.hit = 1'b0;
        events_d    = events_q;
        match       = (bit_in == POLARITY);
        if (clear) begin
            state_d  = '0;
            events_d = '0;
        end else if (accept) begin
            if (match) begin
                if (state_q.count != MAX_C)
                    state_d.count = state_q.count + 1'b1;
                // Only the exact crossing fires, so saturated or longer runs never retrigger.
                state_d.hit = (state_q.count == LEN_M1);
            end else begin
                state_d.count = '0;
            end
`ifdef RUN_DETECT_STICKY_EN
            state_d.led = state_q.led | state_d.hit;
`else
            state_d.led = (state_d.count >= LEN_C);
`endif
            if (state_d.hit && (events_q != {EVW{1'b1}}))
                events_d = events_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= '0;
            events_q <= '0;
        end else begin
            state_q  <= state_d;
            events_q <= events_d;
        end
    end

    assign run_len = state_q.count[CW-1:0];
    assign hit     = state_q.hit;
    assign led     = state_q.led;
    assign events  = events_q;

endmodule

// File: rtl/run_pattern_detector.sv
// Run-length detector top: qualifies samples against clear and maps two run_counter instances to ports.
// Build option: RUN_DETECT_STICKY_EN (sticky LEDs), implemented inside run_counter.
module run_pattern_detector
    import run_detect_pkg::*;
#(
    parameter int  ONES_RUN  = DEF_ONES_RUN,
    parameter int  ZEROS_RUN = DEF_ZEROS_RUN,
    parameter int  MAX_RUN   = DEF_MAX_RUN,
    parameter int  EVW       = DEF_EVW,
    localparam int CW        = run_cw(MAX_RUN)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           bit_in,
    input  logic           bit_valid,
    input  logic           clear,
    output logic [CW-1:0]  ones_run_len,
    output logic [CW-1:0]  zeros_run_len,
    output logic           ones_hit,
    output logic           zeros_hit,
    output logic           led_ones,
    output logic           led_zeros,
    output logic [EVW-1:0] ones_events,
    output logic [EVW-1:0] zeros_events
);

    if (ONES_RUN < 1 || ONES_RUN > MAX_RUN) begin : g_bad_ones_run
        $error("run_pattern_detector: ONES_RUN must be in 1..MAX_RUN");
    end
    if (ZEROS_RUN < 1 || ZEROS_RUN > MAX_RUN) begin : g_bad_zeros_run
        $error("run_pattern_detector: ZEROS_RUN must be in 1..MAX_RUN");
    end
    if (MAX_RUN < 1 || CW > RUN_CNT_W) begin : g_bad_max_run
        $error("run_pattern_detector: MAX_RUN out of supported range");
    end
    if (EVW < 1) begin : g_bad_evw
        $error("run_pattern_detector: EVW must be at least 1");
    end

    // A sample coinciding with clear is dropped.
    logic accept;
    assign accept = bit_valid & ~clear;

    run_counter #(
        .POLARITY (1'b1),
        .RUN_LEN  (ONES_RUN),
        .MAX_RUN  (MAX_RUN),
        .EVW      (EVW)
    ) u_ones (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .accept  (accept),
        .bit_in  (bit_in),
        .run_len (ones_run_len),
        .hit     (ones_hit),
        .led     (led_ones),
        .events  (ones_events)
    );

    run_counter #(
        .POLARITY (1'b0),
        .RUN_LEN  (ZEROS_RUN),
        .MAX_RUN  (MAX_RUN),
        .EVW      (EVW)
    ) u_zeros (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .accept  (accept),
        .bit_in  (bit_in),
        .run_len (zeros_run_len),
        .hit     (zeros_hit),
        .led     (led_zeros),
        .events  (zeros_events)
    );

endmodule
